// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding
// and the default response timeout.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin select: on a tie the requester that did not win
// last time is chosen; last_owner only moves when upd is asserted.
module rr_arb2
  import mem_port_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   req_if,
  input  logic   req_d,
  input  logic   upd,
  output owner_e win,
  output logic   any
);

  owner_e last_owner;

  assign any = req_if | req_d;

  always_comb begin
    win = OWN_IF;
    if (req_if && req_d) begin
      win = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
    end else if (req_d) begin
      win = OWN_D;
    end
  end

  // Seeding last_owner with the opposite side makes the preferred side win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= DATA_FIRST ? OWN_IF : OWN_D;
    end else if (upd && any) begin
      last_owner <= win;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (D),
// one outstanding transaction at a time, with a response-timeout watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_gnt,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state;
  owner_e              owner;
  logic [CNT_W-1:0]    cnt;
  logic                err_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  owner_e              win;
  logic                any;
  logic                grant;
  logic                resp_ok;
  logic                resp_to;
  logic                resp;
  logic                live;
  logic [DATA_W-1:0]   resp_data;

  rr_arb2 #(
    .DATA_FIRST(DATA_FIRST)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_if(if_req),
    .req_d (d_req),
    .upd   (state == IDLE),
    .win   (win),
    .any   (any)
  );

  // Every output is forced low while rst is high, even mid-transaction.
  assign live      = ~rst;
  assign grant     = (state == IDLE) && any;
  assign resp_ok   = (state == WAIT) && m_rvalid;
  assign resp_to   = (state == WAIT) && !m_rvalid && (cnt == CNT_LAST);
  assign resp      = resp_ok | resp_to;
  assign resp_data = resp_ok ? m_rdata : '0;

  assign if_gnt    = live && grant && (win == OWN_IF);
  assign d_gnt     = live && grant && (win == OWN_D);
  assign if_rvalid = live && resp && (owner == OWN_IF);
  assign d_rvalid  = live && resp && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? resp_data : '0;
  assign d_rdata   = d_rvalid ? resp_data : '0;

  assign m_req     = live && (state == REQ);
  assign m_we      = live && we_q;
  assign m_be      = live ? be_q : '0;
  assign m_addr    = live ? addr_q : '0;
  assign m_wdata   = live ? wdata_q : '0;
  assign busy      = live && (state != IDLE);
  assign err       = live && err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      cnt     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner <= win;
            state <= REQ;
            if (win == OWN_D) begin
              we_q    <= d_we;
              be_q    <= d_be;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              we_q    <= 1'b0;
              be_q    <= '1;
              addr_q  <= if_addr;
              wdata_q <= '0;
            end
          end
        end
        REQ: begin
          // A response before the memory has accepted the request is a protocol error.
          if (m_rvalid) begin
            err_q <= 1'b1;
          end
          if (m_gnt) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (m_rvalid) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
